// File: rtl/bpred_pc_unit.sv
// Fetch-side PC register with predecode and a direct-mapped BHT of saturating counters.
// Optional resolve/mispredict statistics counters are built when BPRED_STATS_EN is defined.
module bpred_pc_unit #(
    parameter int          BHT_DEPTH = 64,
    parameter int          CTR_BITS  = 2,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_i,
    input  logic [31:0] instr_i,
    output logic [31:0] pc_o,
    output logic        pred_taken_o,
    output logic [31:0] pred_target_o,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        resolve_valid_i,
    input  logic [31:0] resolve_pc_i,
    input  logic        resolve_taken_i,
    output logic [31:0] br_cnt_o,
    output logic [31:0] mispred_cnt_o
);
    localparam int IDX_W = $clog2(BHT_DEPTH);
    localparam int CTR_INIT_INT = (32'sd1 <<< (CTR_BITS - 1)) - 32'sd1;
    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_INIT_INT[CTR_BITS-1:0];
    localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};
    localparam logic [CTR_BITS-1:0] CTR_MIN  = {CTR_BITS{1'b0}};
    localparam logic [CTR_BITS-1:0] CTR_ONE  = CTR_BITS'(32'd1);

    localparam logic [5:0] OP_BVAR = 6'd1;
    localparam logic [5:0] OP_J    = 6'd2;
    localparam logic [5:0] OP_JAL  = 6'd3;
    localparam logic [5:0] OP_BEQ  = 6'd4;
    localparam logic [5:0] OP_BNE  = 6'd5;
    localparam logic [5:0] OP_BLEZ = 6'd6;
    localparam logic [5:0] OP_BGTZ = 6'd7;

    logic [31:0]         pc_r;
    logic [31:0]         next_pc_s;
    logic [31:0]         seq_s;
    logic [31:0]         br_target_s;
    logic [31:0]         jmp_target_s;
    logic [5:0]          op_s;
    logic [IDX_W-1:0]    lookup_idx_s;
    logic [IDX_W-1:0]    train_idx_s;
    logic [CTR_BITS-1:0] bht_r [BHT_DEPTH];
    logic                unused_s;

    assign op_s         = instr_i[31:26];
    assign seq_s        = pc_r + 32'd4;
    assign br_target_s  = seq_s + {{14{instr_i[15]}}, instr_i[15:0], 2'b00};
    assign jmp_target_s = {seq_s[31:28], instr_i[25:0], 2'b00};
    assign lookup_idx_s = pc_r[IDX_W+1:2];
    assign train_idx_s  = resolve_pc_i[IDX_W+1:2];
    assign unused_s     = ^{resolve_pc_i[31:IDX_W+2], resolve_pc_i[1:0]};
    assign pc_o         = pc_r;

    // Predecode: classify the fetched opcode and pick prediction and target.
    always_comb begin
        pred_taken_o  = 1'b0;
        pred_target_o = seq_s;
        case (op_s)
            OP_BVAR, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
                pred_taken_o  = bht_r[lookup_idx_s][CTR_BITS-1];
                pred_target_o = br_target_s;
            end
            OP_J, OP_JAL: begin
                pred_taken_o  = 1'b1;
                pred_target_o = jmp_target_s;
            end
            default: begin
                pred_taken_o  = 1'b0;
                pred_target_o = seq_s;
            end
        endcase
    end

    // Next-PC selection: a redirect overrides a stall, which overrides the prediction.
    always_comb begin
        next_pc_s = seq_s;
        if (redirect_i) begin
            next_pc_s = redirect_pc_i;
        end else if (stall_i) begin
            next_pc_s = pc_r;
        end else if (pred_taken_o) begin
            next_pc_s = pred_target_o;
        end else begin
            next_pc_s = seq_s;
        end
    end

    // PC register.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r <= RESET_PC;
        end else begin
            pc_r <= next_pc_s;
        end
    end

    // BHT training; the same-cycle lookup sees the value before this update.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht_r[i] <= CTR_INIT;
            end
        end else if (resolve_valid_i) begin
            if (resolve_taken_i) begin
                if (bht_r[train_idx_s] != CTR_MAX) begin
                    bht_r[train_idx_s] <= bht_r[train_idx_s] + CTR_ONE;
                end
            end else if (bht_r[train_idx_s] != CTR_MIN) begin
                bht_r[train_idx_s] <= bht_r[train_idx_s] - CTR_ONE;
            end
        end
    end

`ifdef BPRED_STATS_EN
    logic [31:0] br_cnt_r;
    logic [31:0] mispred_cnt_r;

    // Free-running statistics, wrapping at 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            br_cnt_r      <= 32'd0;
            mispred_cnt_r <= 32'd0;
        end else begin
            if (resolve_valid_i) begin
                br_cnt_r <= br_cnt_r + 32'd1;
            end
            if (redirect_i) begin
                mispred_cnt_r <= mispred_cnt_r + 32'd1;
            end
        end
    end

    assign br_cnt_o      = br_cnt_r;
    assign mispred_cnt_o = mispred_cnt_r;
`else
    assign br_cnt_o      = 32'd0;
    assign mispred_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_bpred_pc_unit.sv
// Scoreboard bench for bpred_pc_unit: an integer-level reference model produces the
// expected fetch state each cycle; a separate monitor pops and compares it.
module tb_bpred_pc_unit;
    localparam logic [31:0] RPC  = 32'h0040_0000;
    localparam int          NENT = 64;
    localparam int          CMAX = 3;
    localparam int          HALF = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall_i = 1'b0;
    logic [31:0] instr_i = 32'd0;
    logic [31:0] pc_o;
    logic        pred_taken_o;
    logic [31:0] pred_target_o;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = 32'd0;
    logic        resolve_valid_i = 1'b0;
    logic [31:0] resolve_pc_i = 32'd0;
    logic        resolve_taken_i = 1'b0;
    logic [31:0] br_cnt_o;
    logic [31:0] mispred_cnt_o;

    bpred_pc_unit #(.BHT_DEPTH(NENT), .CTR_BITS(2), .RESET_PC(RPC)) dut (
        .clk(clk), .reset(reset), .stall_i(stall_i), .instr_i(instr_i),
        .pc_o(pc_o), .pred_taken_o(pred_taken_o), .pred_target_o(pred_target_o),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .resolve_valid_i(resolve_valid_i), .resolve_pc_i(resolve_pc_i),
        .resolve_taken_i(resolve_taken_i), .br_cnt_o(br_cnt_o),
        .mispred_cnt_o(mispred_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        tk;
        logic [31:0] tgt;
        logic [31:0] brc;
        logic [31:0] mpc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state
    logic [31:0] pc_m;
    int          ctr_m [NENT];
    logic [31:0] brc_m;
    logic [31:0] mpc_m;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, expv, $time);
        end
    endtask

    // Monitor: the DUT presents a fetch every cycle; compare it against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("pc_o", pc_o, e.pc);
            check("pred_taken_o", {31'd0, pred_taken_o}, {31'd0, e.tk});
            check("pred_target_o", pred_target_o, e.tgt);
            check("br_cnt_o", br_cnt_o, e.brc);
            check("mispred_cnt_o", mispred_cnt_o, e.mpc);
        end
    end

    task automatic step(input logic rst, input logic st, input logic [31:0] ins,
                        input logic rd, input logic [31:0] rdpc,
                        input logic rv, input logic [31:0] rvpc, input logic rvt);
        exp_t        e;
        int          op;
        int          idx;
        logic [31:0] seq;
        @(negedge clk);
        reset = rst; stall_i = st; instr_i = ins;
        redirect_i = rd; redirect_pc_i = rdpc;
        resolve_valid_i = rv; resolve_pc_i = rvpc; resolve_taken_i = rvt;
        if (rst) begin
            pc_m = RPC;
            for (int i = 0; i < NENT; i++) ctr_m[i] = HALF - 1;
            brc_m = 32'd0;
            mpc_m = 32'd0;
        end else begin
            op  = int'(ins[31:26]);
            seq = pc_m + 32'd4;
            idx = int'((pc_m / 32'd4) % NENT);
            e.pc = pc_m; e.brc = brc_m; e.mpc = mpc_m;
            if (op == 1 || (op >= 4 && op <= 7)) begin
                e.tk  = (ctr_m[idx] >= HALF);
                e.tgt = seq + 32'(4 * int'($signed(ins[15:0])));
            end else if (op == 2 || op == 3) begin
                e.tk  = 1'b1;
                e.tgt = (seq & 32'hF000_0000) + 32'(ins[25:0]) * 32'd4;
            end else begin
                e.tk  = 1'b0;
                e.tgt = seq;
            end
            exp_q.push_back(e);
            if (rd)          pc_m = rdpc;
            else if (st)     pc_m = pc_m;
            else if (e.tk)   pc_m = e.tgt;
            else             pc_m = seq;
            if (rv) begin
                idx = int'((rvpc / 32'd4) % NENT);
                if (rvt) ctr_m[idx] = (ctr_m[idx] + 1 > CMAX) ? CMAX : ctr_m[idx] + 1;
                else     ctr_m[idx] = (ctr_m[idx] - 1 < 0) ? 0 : ctr_m[idx] - 1;
            end
`ifdef BPRED_STATS_EN
            if (rv) brc_m = brc_m + 32'd1;
            if (rd) mpc_m = mpc_m + 32'd1;
`endif
        end
    endtask

    task automatic fetch(input logic [31:0] ins);
        step(1'b0, 1'b0, ins, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic go(input logic [31:0] target);
        step(1'b0, 1'b0, 32'd0, 1'b1, target, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic train(input logic [31:0] ins, input logic [31:0] bpc, input logic tk);
        step(1'b0, 1'b1, ins, 1'b0, 32'd0, 1'b1, bpc, tk);
    endtask

    localparam logic [31:0] NOP = 32'h0000_0000;
    localparam logic [31:0] BEQ3 = {6'd4, 10'd0, 16'h0003};

    initial begin
        logic [31:0] ins;
        logic [5:0]  ops [10];
        ops = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd8, 6'd35};

        step(1'b1, 1'b0, NOP, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        step(1'b1, 1'b0, NOP, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        for (int i = 0; i < 4; i++) fetch(NOP);

        // Redirect wins over a simultaneous stall; then stall alone holds.
        step(1'b0, 1'b1, NOP, 1'b1, 32'h0000_2000, 1'b0, 32'd0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, NOP, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);

        // BEQ at 0x100: weakly not-taken, train twice, refetch predicts taken.
        go(32'h0000_0100);
        fetch(BEQ3);
        go(32'h0000_0100);
        train(BEQ3, 32'h0000_0100, 1'b1);
        train(BEQ3, 32'h0000_0100, 1'b1);
        fetch(BEQ3);
        fetch(NOP);

        // J inside the 0x1000_0000 region.
        go(32'h1000_0000);
        fetch({6'd2, 26'h000_0040});
        fetch(NOP);

        // Saturation both ways, plus lookup during an update at the same index.
        go(32'h0000_0300);
        for (int i = 0; i < 5; i++) train(BEQ3, 32'h0000_0300, 1'b0);
        step(1'b0, 1'b1, BEQ3, 1'b0, 32'd0, 1'b1, 32'h0000_0300, 1'b1);
        for (int i = 0; i < 5; i++) train(BEQ3, 32'h0000_0300, 1'b1);
        step(1'b0, 1'b1, BEQ3, 1'b0, 32'd0, 1'b1, 32'h0000_0300, 1'b0);
        fetch(BEQ3);

        // PC wrap-around.
        go(32'hFFFF_FFFC);
        fetch(NOP);
        fetch(NOP);

        // Reset takes priority over a redirect.
        step(1'b1, 1'b0, NOP, 1'b1, 32'h0000_5000, 1'b1, 32'h0000_0300, 1'b1);
        fetch(BEQ3);

        // Randomized traffic over a small PC window so the BHT entries get exercised.
        go(32'h0000_0400);
        for (int i = 0; i < 400; i++) begin
            ins = {ops[$urandom_range(9, 0)], 26'($urandom())};
            if (ins[31:26] == 6'd2 || ins[31:26] == 6'd3) ins[25:8] = 18'd0;
            step(1'b0, ($urandom_range(4, 0) == 0), ins,
                 ($urandom_range(9, 0) == 0), {22'd0, 8'($urandom()), 2'b00},
                 ($urandom_range(2, 0) == 0), {22'd0, 8'($urandom()), 2'b00},
                 1'($urandom()));
        end

        @(negedge clk);
        #5;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d expected=0 pending", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
